// File: rtl/buzz_1.sv
// Chime generator: steps through an 8-note C5..C6 scale, each note a square wave
// for NOTE_LEN cycles followed by GAP_LEN silent cycles, repeating forever.
module buzz_1 #(
    parameter int NOTE_LEN   = 25_000_000,
    parameter int GAP_LEN    = 2_500_000,
    parameter int TONE_SHIFT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        spek,
    output logic [17:0] counter,
    output logic        sound
);

    localparam int MAX_LEN = (NOTE_LEN > GAP_LEN) ? NOTE_LEN : GAP_LEN;
    localparam int TW_REQ  = $clog2(MAX_LEN + 1);
    localparam int TW      = (TW_REQ > 25) ? TW_REQ : 25;

    localparam logic [TW-1:0] NOTE_END = TW'(NOTE_LEN - 1);
    localparam logic [TW-1:0] GAP_END  = TW'(GAP_LEN - 1);

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_NOTE  = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    // Half-period at 100 MHz, scaled down for simulation; never allowed to reach 0.
    function automatic logic [17:0] half_period(input logic [2:0] idx);
        logic [17:0] raw;
        logic [17:0] sh;
        case (idx)
            3'd0:    raw = 18'd95556;
            3'd1:    raw = 18'd85131;
            3'd2:    raw = 18'd75843;
            3'd3:    raw = 18'd71586;
            3'd4:    raw = 18'd63776;
            3'd5:    raw = 18'd56818;
            3'd6:    raw = 18'd50619;
            default: raw = 18'd47778;
        endcase
        sh = raw >> TONE_SHIFT;
        return (sh == 18'd0) ? 18'd1 : sh;
    endfunction

    state_t        r_state;
    logic [2:0]    r_idx;
    logic [TW-1:0] r_tmr;
    logic [17:0]   r_cnt;
    logic          r_spek;
    logic          r_sound;

    state_t        w_state_nxt;
    logic [2:0]    w_idx_nxt;
    logic [TW-1:0] w_tmr_nxt;
    logic [17:0]   w_cnt_nxt;
    logic          w_spek_nxt;
    logic [17:0]   w_half_m1;

    assign w_half_m1 = half_period(r_idx) - 18'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_START;
            r_idx   <= 3'd0;
            r_tmr   <= '0;
            r_cnt   <= 18'd0;
            r_spek  <= 1'b0;
            r_sound <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_tmr   <= w_tmr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_spek  <= w_spek_nxt;
            r_sound <= (w_state_nxt == S_NOTE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_tmr_nxt   = r_tmr;
        w_cnt_nxt   = r_cnt;
        w_spek_nxt  = r_spek;
        case (r_state)
            S_START: begin
                w_state_nxt = S_NOTE;
                w_idx_nxt   = 3'd0;
                w_tmr_nxt   = '0;
                w_cnt_nxt   = 18'd0;
                w_spek_nxt  = 1'b0;
            end
            S_NOTE: begin
                // Note end wins over a divider wrap on the same edge.
                if (r_tmr == NOTE_END) begin
                    w_state_nxt = S_GAP;
                    w_tmr_nxt   = '0;
                    w_cnt_nxt   = 18'd0;
                    w_spek_nxt  = 1'b0;
                end else begin
                    w_tmr_nxt = r_tmr + TW'(1);
                    if (r_cnt == w_half_m1) begin
                        w_cnt_nxt  = 18'd0;
                        w_spek_nxt = ~r_spek;
                    end else begin
                        w_cnt_nxt = r_cnt + 18'd1;
                    end
                end
            end
            S_GAP: begin
                w_cnt_nxt  = 18'd0;
                w_spek_nxt = 1'b0;
                if (r_tmr == GAP_END) begin
                    w_state_nxt = S_NOTE;
                    w_tmr_nxt   = '0;
                    w_idx_nxt   = r_idx + 3'd1;
                end else begin
                    w_tmr_nxt = r_tmr + TW'(1);
                end
            end
            default: begin
                w_state_nxt = S_START;
                w_idx_nxt   = 3'd0;
                w_tmr_nxt   = '0;
                w_cnt_nxt   = 18'd0;
                w_spek_nxt  = 1'b0;
            end
        endcase
    end

    assign spek    = r_spek;
    assign counter = r_cnt;
    assign sound   = r_sound;

endmodule

// File: tb/tb_buzz_1.sv
// Bench for buzz_1: closed-form scale model checked every cycle, hand vectors,
// toggle-spacing measurement, async reset aborts and an H=1 corner instance.
module tb_buzz_1;

    logic        clk;
    logic        rst_n;
    logic        spek1, sound1, spek2, sound2;
    logic [17:0] cnt1, cnt2;

    buzz_1 #(.NOTE_LEN(1000), .GAP_LEN(100), .TONE_SHIFT(10)) d1 (
        .clk(clk), .rst_n(rst_n), .spek(spek1), .counter(cnt1), .sound(sound1));

    // Shift large enough that every half-period collapses to 1; very short note/gap.
    buzz_1 #(.NOTE_LEN(3), .GAP_LEN(1), .TONE_SHIFT(17)) d2 (
        .clk(clk), .rst_n(rst_n), .spek(spek2), .counter(cnt2), .sound(sound2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int k     = 0;

    int prev_spek, prev_sound, last_k, note_n;
    int exp_sp [8];

    typedef struct {
        int   k;
        logic spek;
        int   cnt;
        logic snd;
    } vec_t;
    vec_t vecs [14];

    function automatic int tbl(input int i);
        case (i)
            0: return 95556;
            1: return 85131;
            2: return 75843;
            3: return 71586;
            4: return 63776;
            5: return 56818;
            6: return 50619;
            default: return 47778;
        endcase
    endfunction

    // Expected {spek, counter, sound} after k edges since reset release.
    function automatic logic [31:0] model(input int kk, input int sh, input int n, input int g);
        int p, note, q, h;
        logic sp, sn;
        int c;
        sp = 1'b0; sn = 1'b0; c = 0;
        if (kk > 0) begin
            p    = (kk - 1) % (8 * (n + g));
            note = p / (n + g);
            q    = p % (n + g);
            if (q < n) begin
                h = tbl(note) >> sh;
                if (h == 0) h = 1;
                sn = 1'b1;
                c  = q % h;
                sp = ((q / h) % 2) == 1;
            end
        end
        return {12'd0, sp, 18'(c), sn};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic trk_reset();
        prev_spek = 0; prev_sound = 0; last_k = 0; note_n = 7;
    endtask

    task automatic chk_model();
        chk($sformatf("d1 k=%0d", k), {12'd0, spek1, cnt1, sound1}, model(k, 10, 1000, 100));
        chk($sformatf("d2 k=%0d", k), {12'd0, spek2, cnt2, sound2}, model(k, 17, 3, 1));
    endtask

    // Toggle-spacing measurement on d1, spacing counted from note entry or last toggle.
    task automatic track();
        if (sound1 && prev_sound == 0) begin
            note_n = (note_n + 1) % 8;
            last_k = k;
        end else if (sound1 && int'(spek1) != prev_spek) begin
            chk($sformatf("spacing note%0d k=%0d", note_n, k), 32'(k - last_k), 32'(exp_sp[note_n]));
            last_k = k;
        end
        prev_spek  = int'(spek1);
        prev_sound = int'(sound1);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) k++;
        @(negedge clk);
        chk_model();
        track();
    endtask

    // Called at a negedge; asserts reset between edges and checks outputs clear at once.
    task automatic async_reset(input int dly, input int hold);
        #(dly);
        rst_n = 1'b0;
        #1;
        chk("async d1", {12'd0, spek1, cnt1, sound1}, 32'd0);
        chk("async d2", {12'd0, spek2, cnt2, sound2}, 32'd0);
        k = 0;
        @(negedge clk);
        for (int i = 0; i < hold; i++) tick();
        rst_n = 1'b1;
        trk_reset();
        #1;
        chk_model();
    endtask

    initial begin
        exp_sp = '{93, 83, 74, 69, 62, 55, 49, 46};
        vecs[0]  = '{0,    1'b0, 0,  1'b0};
        vecs[1]  = '{1,    1'b0, 0,  1'b1};
        vecs[2]  = '{93,   1'b0, 92, 1'b1};
        vecs[3]  = '{94,   1'b1, 0,  1'b1};
        vecs[4]  = '{187,  1'b0, 0,  1'b1};
        vecs[5]  = '{1000, 1'b0, 69, 1'b1};
        vecs[6]  = '{1001, 1'b0, 0,  1'b0};
        vecs[7]  = '{1100, 1'b0, 0,  1'b0};
        vecs[8]  = '{1101, 1'b0, 0,  1'b1};
        vecs[9]  = '{1183, 1'b0, 82, 1'b1};
        vecs[10] = '{1184, 1'b1, 0,  1'b1};
        vecs[11] = '{8800, 1'b0, 0,  1'b0};
        vecs[12] = '{8801, 1'b0, 0,  1'b1};
        vecs[13] = '{8894, 1'b1, 0,  1'b1};

        rst_n = 1'b0;
        trk_reset();
        #1;
        chk("reset d1", {12'd0, spek1, cnt1, sound1}, 32'd0);
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b1;
        trk_reset();

        foreach (vecs[v]) begin
            for (int n = 0; n < 20000 && k < vecs[v].k; n++) tick();
            chk($sformatf("vec%0d reach", v), 32'(k), 32'(vecs[v].k));
            chk($sformatf("vec%0d k=%0d", v, vecs[v].k), {12'd0, spek1, cnt1, sound1},
                {12'd0, vecs[v].spek, 18'(vecs[v].cnt), vecs[v].snd});
        end

        // Abort in the middle of note 3, then expect playback to restart from C5.
        for (int n = 0; n < 20000 && k != 8800 + 3 * 1100 + 500; n++) tick();
        chk("mid note3 sound", 32'(sound1), 32'd1);
        async_reset(2, 3);
        begin
            int rise_k;
            rise_k = -1;
            for (int n = 0; n < 300 && rise_k < 0; n++) begin
                tick();
                if (spek1) rise_k = k;
            end
            chk("restart first rise", 32'(rise_k - 1), 32'd93);
        end

        repeat (8) begin
            int len;
            len = $urandom_range(1, 4000);
            for (int n = 0; n < len; n++) tick();
            async_reset($urandom_range(1, 3), $urandom_range(1, 3));
        end
        for (int n = 0; n < 500; n++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
